// File: rtl/obf_key_loader.sv
// Serial key loader: hunts for a sync word, shifts in a key frame,
// checks parity and framing, then commits the key to d_key in one step.
module obf_key_loader #(
  parameter  int          NUM_CELLS = 5,
  parameter  logic [7:0]  SYNC_WORD = 8'hA5,
  localparam int          KEY_W     = 2 * NUM_CELLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_data,
  input  logic             s_last,
  output logic [KEY_W-1:0] d_key,
  output logic             key_valid,
  output logic             key_update,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(KEY_W);
  localparam logic [CW-1:0] LAST = CW'(KEY_W - 1);

  typedef enum logic [1:0] {
    HUNT,
    KEY,
    PARITY,
    CHECK
  } state_t;

  state_t           state;
  logic [7:0]       win;
  logic [7:0]       win_nx;
  logic [KEY_W-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic             frame_bad;
  logic             acc;

  assign s_ready = (state != CHECK);
  assign busy    = (state != HUNT);
  assign acc     = s_valid && s_ready;
  assign win_nx  = {win[6:0], s_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      win        <= '0;
      shadow     <= '0;
      cnt        <= '0;
      frame_bad  <= 1'b0;
      d_key      <= '0;
      key_valid  <= 1'b0;
      key_update <= 1'b0;
      err        <= 1'b0;
    end else begin
      key_update <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        HUNT: begin
          if (acc) begin
            win <= win_nx;
            if (win_nx == SYNC_WORD) begin
              state     <= KEY;
              cnt       <= '0;
              frame_bad <= 1'b0;
            end
          end
        end
        KEY: begin
          if (acc) begin
            shadow[cnt] <= s_data;
            cnt         <= cnt + CW'(1);
            if (s_last) begin
              frame_bad <= 1'b1;
              state     <= CHECK;
            end else if (cnt == LAST) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (acc) begin
            frame_bad <= (s_data != ^shadow) || !s_last;
            state     <= CHECK;
          end
        end
        CHECK: begin
          // Window restarts empty so stale key bits never alias a sync.
          win   <= '0;
          state <= HUNT;
          if (frame_bad) begin
            err <= 1'b1;
          end else begin
            d_key      <= shadow;
            key_valid  <= 1'b1;
            key_update <= 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_obf_key_loader.sv
// Randomized frame stimulus against a frame-level model of the
// expected commit/reject outcome for obf_key_loader.
module tb_obf_key_loader;

  localparam int KW = 10;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic          s_data;
  logic          s_last;
  logic [KW-1:0] d_key;
  logic          key_valid;
  logic          key_update;
  logic          err;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_upd = 0;
  int n_err = 0;
  int exp_upd = 0;
  int exp_err = 0;
  int stall_pct = 0;
  logic [KW-1:0] exp_key;
  logic          exp_valid;

  obf_key_loader #(
    .NUM_CELLS(5),
    .SYNC_WORD(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .d_key(d_key),
    .key_valid(key_valid),
    .key_update(key_update),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_update) n_upd++;
    if (err) n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Frame outcome straight from the frame rules.
  function automatic logic frame_ok(logic [KW-1:0] key, logic par,
                                    logic early, logic par_last);
    return !early && par_last && (par == ^key);
  endfunction

  task automatic beat(logic d, logic l);
    int g = 0;
    while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
      s_valid = 1'b0;
      s_data  = 1'($urandom);
      s_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    while (!s_ready && g < 8) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    if (!s_ready) chk("ready_timeout", 0, 1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'($urandom);
    s_data  = 1'($urandom);
  endtask

  // kind: 0 good, 1 parity flipped, 2 s_last on key bit pos,
  // 3 parity beat without s_last
  task automatic frame(logic [KW-1:0] key, int kind, int pos, int pre);
    logic par;
    logic ok;
    int c0;
    par = ^key;
    for (int i = 0; i < pre; i++) beat(logic'(i % 2 == 0), 1'($urandom));
    c0 = cyc;
    for (int i = 7; i >= 0; i--) beat(SYNC[i], 1'($urandom));
    for (int i = 0; i < KW; i++) begin
      if (kind == 2 && i == pos) begin
        beat(key[i], 1'b1);
        break;
      end
      beat(key[i], 1'b0);
    end
    if (kind != 2) beat(kind == 1 ? ~par : par, kind != 3);
    ok = frame_ok(key, kind == 1 ? ~par : par, kind == 2, kind != 3);
    chk("busy_in_check", busy, 1);
    chk("ready_in_check", s_ready, 0);
    @(posedge clk); #1;
    if (ok) begin
      exp_key   = key;
      exp_valid = 1'b1;
      exp_upd++;
    end else begin
      exp_err++;
    end
    chk("ready_back", s_ready, 1);
    chk("busy_back", busy, 0);
    chk("d_key", d_key, exp_key);
    chk("key_valid", key_valid, exp_valid);
    chk("key_update", key_update, ok);
    chk("err", err, !ok);
    if (stall_pct == 0 && pre == 0 && kind != 2)
      chk("commit_latency", cyc - c0, KW + 10);
    @(posedge clk); #1;
    chk("upd_pulse_end", key_update, 0);
    chk("err_pulse_end", err, 0);
    chk("upd_count", n_upd, exp_upd);
    chk("err_count", n_err, exp_err);
  endtask

  initial begin
    logic [KW-1:0] k;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = 1'b0;
    s_last    = 1'b0;
    exp_key   = '0;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_d_key", d_key, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_key_update", key_update, 0);
    chk("rst_err", err, 0);

    frame(10'h384, 0, -1, 0);
    frame(10'h384, 1, -1, 0);
    frame(10'h3FF, 0, -1, 0);
    frame(10'h155, 2, 3, 0);
    frame(10'h2AA, 0, -1, 0);
    frame(10'h0F0, 3, -1, 0);
    frame(10'h1C3, 2, KW - 1, 0);
    stall_pct = 30;
    frame(10'h384, 0, -1, 4);
    stall_pct = 0;

    for (int i = 7; i >= 0; i--) beat(SYNC[i], 1'b0);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    exp_key   = '0;
    exp_valid = 1'b0;
    chk("midrst_d_key", d_key, 0);
    chk("midrst_key_valid", key_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", s_ready, 1);
    frame(10'h0F3, 0, -1, 0);

    repeat (20) begin
      k         = KW'($urandom);
      stall_pct = $urandom_range(1) ? 30 : 0;
      frame(k, $urandom_range(3), $urandom_range(KW - 1),
            $urandom_range(1) ? 4 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
